// File: rtl/heart_rate_sequencer_pkg.sv
// Shared types and constants for the heart-rate sequencer.
// Holds the FSM state encoding and the count-to-BPM scaling helpers.
// No logic; imported by the interface and the top block.
package heart_rate_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    LATCH
  } state_t;

  localparam int BPM_W         = 8;
  localparam int BPM_SAT       = 255;
  localparam int DEF_WINDOW_MS = 15000;

  // Beats counted in one window times this factor gives beats per minute.
  function automatic int bpm_mul(input int window_ms);
    return 60000 / window_ms;
  endfunction

  localparam int BPM_MUL = bpm_mul(DEF_WINDOW_MS);

endpackage

// File: rtl/heart_rate_sequencer_if.sv
// Control/result bundle between the sensor-side controller and the sequencer.
// master drives start/stop/continuous and the raw beat pin; slave is the sequencer.
// Pure wiring, no timing of its own.
interface heart_rate_sequencer_if;
  import heart_rate_sequencer_pkg::*;

  logic             start;
  logic             stop;
  logic             continuous;
  logic             beat_in;
  logic             beat_pulse;
  logic             busy;
  logic             window_done;
  logic [BPM_W-1:0] bpm_out;
  logic             bpm_valid;
  logic             alarm_low;
  logic             alarm_high;

  modport master (
    output start, stop, continuous, beat_in,
    input  beat_pulse, busy, window_done, bpm_out, bpm_valid, alarm_low, alarm_high
  );

  modport slave (
    input  start, stop, continuous, beat_in,
    output beat_pulse, busy, window_done, bpm_out, bpm_valid, alarm_low, alarm_high
  );

endinterface

// File: rtl/heart_rate_sequencer_ms_tick_gen.sv
// Millisecond tick divider: one-cycle tick every TICK_DIV clk cycles.
// First tick TICK_DIV cycles after clear is released.
// clear restarts the divider phase so windows start on a fresh millisecond.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted by clear and on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/heart_rate_sequencer.sv
// Heart-beat counting sequencer: debounced beat capture, settle/measure windows, BPM and alarms.
// beat_in rise to beat_pulse is 3 cycles; result latched one cycle after the last window tick.
// No backpressure: start is ignored while busy, stop aborts to IDLE keeping the last result.
module heart_rate_sequencer
  import heart_rate_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int WINDOW_MS  = DEF_WINDOW_MS,
  parameter int SETTLE_MS  = 500,
  parameter int REFRACT_MS = 250,
  parameter int BPM_LOW    = 60,
  parameter int BPM_HIGH   = 180,
  parameter int COUNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  heart_rate_sequencer_if.slave bus
);

  localparam int MUL    = bpm_mul(WINDOW_MS);
  localparam int MS_MAX = (WINDOW_MS > SETTLE_MS) ? WINDOW_MS : SETTLE_MS;
  localparam int MW     = $clog2(MS_MAX + 1);
  localparam int RW     = (REFRACT_MS > 0) ? $clog2(REFRACT_MS + 1) : 1;
  localparam int PW     = COUNT_W + 16;

  localparam logic [MW-1:0]      SETTLE_LAST = MW'(SETTLE_MS - 1);
  localparam logic [MW-1:0]      WINDOW_LAST = MW'(WINDOW_MS - 1);
  localparam logic [RW-1:0]      REFR_LOAD   = RW'(REFRACT_MS);
  localparam logic [COUNT_W-1:0] CNT_MAX     = {COUNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic               tick;
  logic               tick_clear;
  logic [MW-1:0]      ms_cnt;
  logic               sync1;
  logic               sync2;
  logic               sync2_d;
  logic               rise;
  logic               accept;
  logic [RW-1:0]      refr;
  logic               pulse;
  logic [COUNT_W-1:0] count;
  logic [PW-1:0]      prod;
  logic [BPM_W-1:0]   bpm_calc;
  logic               latch_en;
  logic [BPM_W-1:0]   bpm;
  logic               valid;
  logic               done;
  logic               low;
  logic               high;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  assign rise   = sync2 & ~sync2_d;
  assign accept = rise && (refr == '0);

  // Synchroniser, edge detect and refractory window; held cleared while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      refr    <= '0;
      pulse   <= 1'b0;
    end else if (state == IDLE) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      refr    <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= bus.beat_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= accept;
      if (accept) begin
        refr <= REFR_LOAD;
      end else if (tick && refr != '0) begin
        refr <= refr - 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop dominates and the divider restarts on each window start.
  always_comb begin
    state_nxt  = state;
    tick_clear = 1'b0;
    case (state)
      IDLE: begin
        tick_clear = 1'b1;
        if (bus.start && !bus.stop) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (tick && ms_cnt == SETTLE_LAST) begin
          state_nxt  = MEASURE;
          tick_clear = 1'b1;
        end
      end
      MEASURE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (tick && ms_cnt == WINDOW_LAST) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.continuous) begin
          state_nxt  = MEASURE;
          tick_clear = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Millisecond counter for the current phase; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_cnt <= '0;
    end else if (state == IDLE || state_nxt != state) begin
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  // Beat counter: saturating; a beat landing in LATCH carries into the next window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == SETTLE && state_nxt == MEASURE) begin
      count <= '0;
    end else if (state == LATCH) begin
      count <= (state_nxt == MEASURE && accept) ? COUNT_W'(1) : '0;
    end else if (state == MEASURE && accept && count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  // Full-width product so large counts saturate instead of wrapping.
  assign prod     = PW'(count) * PW'(MUL);
  assign bpm_calc = (prod > PW'(BPM_SAT)) ? BPM_W'(BPM_SAT) : prod[BPM_W-1:0];
  assign latch_en = (state == LATCH) && !bus.stop;

  // Result registers; untouched by stop so the last reading stays on display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bpm   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      low   <= 1'b0;
      high  <= 1'b0;
    end else begin
      done <= latch_en;
      if (latch_en) begin
        bpm   <= bpm_calc;
        valid <= 1'b1;
        low   <= (int'(bpm_calc) < BPM_LOW);
        high  <= (int'(bpm_calc) > BPM_HIGH);
      end
    end
  end

  assign bus.beat_pulse  = pulse;
  assign bus.busy        = (state != IDLE);
  assign bus.window_done = done;
  assign bus.bpm_out     = bpm;
  assign bus.bpm_valid   = valid;
  assign bus.alarm_low   = low;
  assign bus.alarm_high  = high;

endmodule

// File: doc/heart_rate_sequencer.md
Name: heart_rate_sequencer

Overview:
Controller that sequences the heart-beat counting datapath of the rocker.
- Synchronises the raw beat input and rejects contact bounce with a refractory window.
- Generates the settle and measurement windows from clk and counts accepted beats.
- Converts the count to beats per minute and raises low/high alarms.
- Sits between the heart sensor input pin and the display/rocking-control logic; supports single-shot and continuous measurement.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk)
WINDOW_MS, 15000, measurement window length in ms; must divide 60000
SETTLE_MS, 500, settle time after start before counting begins
REFRACT_MS, 250, ignore further edges for this long after an accepted beat
BPM_LOW, 60, alarm_low asserted when bpm < BPM_LOW
BPM_HIGH, 180, alarm_high asserted when bpm > BPM_HIGH
COUNT_W, 8, beat counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin measurement
stop  in  1  one-cycle pulse; abort and return to IDLE
continuous  in  1  1 = restart window automatically after each result
beat_in  in  1  raw asynchronous beat pulse from sensor
beat_pulse  out  1  one-cycle strobe per accepted beat (any non-IDLE state)
busy  out  1  high in any state except IDLE
window_done  out  1  one-cycle strobe when a new result is latched
bpm_out  out  8  last latched beats per minute, saturated at 255
bpm_valid  out  1  bpm_out holds a result from a completed window
alarm_low  out  1  last result below BPM_LOW
alarm_high  out  1  last result above BPM_HIGH

Behaviour:
- Reset: async, active-high; clock clk. All outputs, counters and synchroniser flops go to 0; state goes to IDLE.
- Input path:
  - 2-FF synchroniser on beat_in, then rising-edge detect on the synchronised signal.
  - An edge outside the refractory period is accepted: beat_pulse is high for 1 cycle and the refractory counter loads REFRACT_MS ticks.
  - Edges during the refractory period are ignored.
  - Latency from a beat_in rise to beat_pulse is 3 clk cycles.
  - The input path runs in all non-IDLE states; in IDLE it is held cleared.
- Tick generator: a divider of TICK_DIV cycles produces a 1-cycle ms tick. It is cleared on every entry to SETTLE and on every MEASURE window start.
- FSM states: IDLE, SETTLE, MEASURE, LATCH.
  - IDLE -> SETTLE on start.
  - SETTLE -> MEASURE after SETTLE_MS ticks; the beat counter clears on entry to MEASURE.
  - MEASURE -> LATCH after WINDOW_MS ticks.
  - LATCH lasts 1 cycle:
    - bpm_out = min(count*(60000/WINDOW_MS), 255); multiply at full width before saturating.
    - bpm_valid=1; window_done=1; both alarms updated.
  - LATCH -> MEASURE if continuous=1: counter cleared, no settle, new window starts the next cycle. Otherwise LATCH -> IDLE.
  - stop in any non-IDLE state -> IDLE next cycle.
- Hold rules:
  - On stop, bpm_out, bpm_valid and the alarms keep their previous values.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins.
- Boundary cases:
  - A beat accepted in the same cycle as the last tick of MEASURE is counted in the closing window.
  - A beat accepted during LATCH is counted in the next window (continuous) or dropped.
  - The beat counter saturates at 2^COUNT_W-1; it never wraps.
  - Zero beats in a window gives bpm 0 and alarm_low=1.
  - alarm_low and alarm_high are mutually exclusive by construction; parameters must satisfy BPM_LOW <= BPM_HIGH.
- Reset mid-operation: immediate return to the reset state. The next result requires a new start.

Decomposition:
- Shared package:
  - State enum {IDLE, SETTLE, MEASURE, LATCH}.
  - BPM_MUL = 60000/WINDOW_MS.
  - BPM_SAT = 255.
- Sub-module ms_tick_gen: clk, reset, clear, tick; parameter TICK_DIV.
- Synchroniser, refractory counter, FSM and BPM conversion all live in the top block.

Test Plan:
All tests run with TICK_DIV=2, WINDOW_MS=15000, SETTLE_MS=500 and REFRACT_MS=250, giving a window of 30000 cycles, a settle of 1000 cycles and a refractory of 500 cycles.
1. start, continuous=0, then 20 clean beats 1200 cycles apart inside the window -> window_done at cycle 31001 after start, bpm_out=80, bpm_valid=1, no alarms, busy=0 afterwards.
2. Same as test 1 but 10 beats -> bpm_out=40, alarm_low=1, alarm_high=0. Then a window with 50 beats 550 cycles apart -> bpm_out=200, alarm_high=1, alarm_low=0.
3. Each beat_in pulse followed by 3 bounce edges 5 cycles apart, 15 beats -> 15 beat_pulse strobes, bpm_out=60, alarm_low=0.
4. continuous=1, 20 beats per window -> window_done strobes exactly 30001 cycles apart with bpm_out=80. stop mid-window -> IDLE next cycle, bpm_out stays 80, bpm_valid stays 1.
5. A beat placed on the last tick cycle of MEASURE -> included in the count (e.g. 19+1 gives 80). start and stop pulsed in the same cycle from IDLE -> stays IDLE.
6. reset asserted mid-MEASURE after a previous valid result -> all outputs 0 immediately. start after release gives a normal result 31001 cycles later.
